cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
// - Downstream of the function units (alu and siblings); picks one finished FU result per cycle for the Common Data Bus (CDB).
// - Round-robin arbitration over per-FU next_valid requests; grant is registered.
// - Granted FU's result/tag drive the CDB the following cycle, and that FU gets its broadcasted ack in the same cycle.
// - CDB feeds the PRF write port and RS/ROB wakeup.
// PARAMETERS
// - NUM_FU          4   number of function units arbitrated (>=2)
// - PHYS_REG_WIDTH  6   physical register tag width; matches FU dest_tag width
// PORTS
// - clock               in   1                       rising-edge clock, single domain
// - reset               in   1                       synchronous, active-high
// - clear               in   1                       flush: drop all grants, suppress bus this cycle
// - fu_next_valid       in   NUM_FU                  FU i will hold a valid result next cycle (FU next_valid)
// - fu_result           in   NUM_FU x DATA           FU i held result (FU result)
// - fu_dest_tag         in   NUM_FU x PHYS_REG_WIDTH FU i destination tag
// - fu_dest_tag_wr_en   in   NUM_FU                  FU i result writes the PRF
// - fu_broadcasted      out  NUM_FU                  one-hot ack to FU i: bus is taking its result this cycle
// - cdb_valid           out  1                       CDB carries a result this cycle
// - cdb_data            out  DATA                    broadcast result
// - cdb_tag             out  PHYS_REG_WIDTH          broadcast destination tag
// - cdb_wr_en           out  1                       PRF write enable (cdb_valid & granted wr_en)
// BEHAVIOUR
// - Request vector: req = fu_next_valid & {NUM_FU{~clear}}.
// - Arbitration (cycle t): grant_next = first set bit of req, searching upward from prio_ptr with wrap (prio_ptr, prio_ptr+1 .. NUM_FU-1, 0 .. prio_ptr-1).
//   - grant_ff <= grant_next at end of t; grant_next is one-hot or zero.
// - Pointer: if grant_next != 0, prio_ptr <= (index(grant_next)+1) mod NUM_FU; otherwise it holds.
//   - Wrap from NUM_FU-1 goes to 0.
// - Broadcast (cycle t+1): fu_broadcasted = grant_ff & ~clear.
//   - cdb_valid = |grant_ff & ~clear.
//   - cdb_data, cdb_tag: mux of FU inputs selected by grant_ff.
//   - cdb_wr_en = cdb_valid & fu_dest_tag_wr_en[granted].
// - When cdb_valid=0: cdb_data='0, cdb_tag='0, cdb_wr_en=0 (no stale data on the bus).
// - Latency: a result announced by next_valid in cycle t broadcasts at earliest in t+1, the cycle the FU holds it.
//   - With a single requester, throughput is one result/cycle; a FU may be re-granted back-to-back.
// - Losing FUs keep next_valid high (they hold their result) and re-request every cycle.
//   - Round-robin gives any requester a grant within NUM_FU cycles.
// - Granted FU that accepts new work in t+1 raises next_valid again and is a legal request in t+1.
// - Ack path is registered only (grant_ff); no combinational path from fu_next_valid to fu_broadcasted.
// - Clear in cycle t: no broadcast in t; grant_ff <= 0 and prio_ptr holds.
//   - Arbitration resumes in t+1 from the then-current requests.
// - Reset (sync, active-high): grant_ff=0, prio_ptr=0.
//   - All outputs read 0 in the cycle after reset is sampled and while reset stays high (outputs are gated with ~reset).
// - Reset mid-broadcast: the pending grant is discarded; the FU loses its result through its own reset.
// STRUCTURE
// - sys_defs package:
//   - add typedef struct packed CDB_PACKET {valid, tag[PHYS_REG_WIDTH-1:0], wr_en, DATA data};
//   - tag width uses a package-level PHYS_REG_WIDTH localparam.
//   - cdb_* outputs may later be bundled as CDB_PACKET.
// - Sub-module rr_arbiter #(N): combinational rotate-priority pick (req, prio_ptr -> one-hot grant).
// - cdb_arbiter holds grant_ff, prio_ptr, the output mux and clear/reset gating.
// TESTING
// - Single FU: fu_next_valid=4'b0001 in cycle 1, fu_result[0]=32'h0000_0011, tag 6'd5, wr_en=1
//   -> cycle 2: cdb_valid=1, cdb_data=32'h11, cdb_tag=5, cdb_wr_en=1, fu_broadcasted=4'b0001.
// - All four request continuously from prio_ptr=0
//   -> grants FU0,FU1,FU2,FU3,FU0 in consecutive cycles; fu_broadcasted always one-hot.
// - Wrap: prio_ptr=3, req=4'b1001 -> FU3 granted, pointer becomes 0; next cycle req=4'b1001 -> FU0 granted.
// - Clear: FU1 granted in cycle t, clear=1 in t+1 -> cdb_valid=0, fu_broadcasted=0 in t+1; no grant issued for t+2.
// - wr_en=0 result (tag 6'd0) -> cdb_valid=1, cdb_wr_en=0, fu_broadcasted set.
// - Reset while FU2 granted -> next cycle all outputs 0, prio_ptr=0; first grant after reset favours FU0.

Source files
------------

// File: rtl/sys_defs.sv
// Shared widths and the CDB packet type used by the CDB arbiter and its consumers.
package sys_defs;

    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned PHYS_REG_WIDTH = 6;

    typedef logic [DATA_WIDTH-1:0] DATA;

    // Bundled bus view; the arbiter still drives discrete cdb_* ports today.
    typedef struct packed {
        logic                      valid;
        logic [PHYS_REG_WIDTH-1:0] tag;
        logic                      wr_en;
        DATA                       data;
    } CDB_PACKET;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority pick: first set request at or above prio_ptr_i, wrapping to 0.
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [PtrW-1:0] prio_ptr_i,
    output logic [N-1:0]    grant_o
);

    logic found;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        // Upper segment [ptr, N-1] has priority over the wrapped segment [0, ptr-1].
        for (int i = 0; i < int'(N); i++) begin
            if (i >= int'(prio_ptr_i) && req_i[i] && !found) begin
                grant_o[i] = 1'b1;
                found      = 1'b1;
            end
        end
        for (int i = 0; i < int'(N); i++) begin
            if (i < int'(prio_ptr_i) && req_i[i] && !found) begin
                grant_o[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: registered round-robin grant over FU results, broadcast the next cycle.
module cdb_arbiter
    import sys_defs::DATA_WIDTH;
#(
    parameter int unsigned NUM_FU         = 4,
    parameter int unsigned PHYS_REG_WIDTH = sys_defs::PHYS_REG_WIDTH
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic                                      clear,
    input  logic [NUM_FU-1:0]                         fu_next_valid,
    input  logic [NUM_FU-1:0][DATA_WIDTH-1:0]         fu_result,
    input  logic [NUM_FU-1:0][PHYS_REG_WIDTH-1:0]     fu_dest_tag,
    input  logic [NUM_FU-1:0]                         fu_dest_tag_wr_en,
    output logic [NUM_FU-1:0]                         fu_broadcasted,
    output logic                                      cdb_valid,
    output logic [DATA_WIDTH-1:0]                     cdb_data,
    output logic [PHYS_REG_WIDTH-1:0]                 cdb_tag,
    output logic                                      cdb_wr_en
);

    localparam int unsigned PtrW = $clog2(NUM_FU);

    logic [NUM_FU-1:0] req;
    logic [NUM_FU-1:0] grant_d, grant_q;
    logic [PtrW-1:0]   prio_ptr_d, prio_ptr_q;
    logic              bus_en;

    assign req = fu_next_valid & {NUM_FU{~clear}};

    rr_arbiter #(
        .N (NUM_FU)
    ) u_rr_arbiter (
        .req_i      (req),
        .prio_ptr_i (prio_ptr_q),
        .grant_o    (grant_d)
    );

    // Pointer moves just past the winner so it has lowest priority next round.
    always_comb begin
        prio_ptr_d = prio_ptr_q;
        for (int i = 0; i < int'(NUM_FU); i++) begin
            if (grant_d[i]) begin
                prio_ptr_d = (i == int'(NUM_FU) - 1) ? '0 : PtrW'(i + 1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            grant_q    <= '0;
            prio_ptr_q <= '0;
        end else begin
            grant_q    <= grant_d;
            prio_ptr_q <= prio_ptr_d;
        end
    end

    // AND-OR mux on the one-hot grant; everything reads zero when the bus is idle.
    always_comb begin
        bus_en         = ~clear & ~reset;
        fu_broadcasted = grant_q & {NUM_FU{bus_en}};
        cdb_valid      = |fu_broadcasted;
        cdb_data       = '0;
        cdb_tag        = '0;
        cdb_wr_en      = 1'b0;
        for (int i = 0; i < int'(NUM_FU); i++) begin
            if (fu_broadcasted[i]) begin
                cdb_data  = cdb_data | fu_result[i];
                cdb_tag   = cdb_tag | fu_dest_tag[i];
                cdb_wr_en = cdb_wr_en | fu_dest_tag_wr_en[i];
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed, table-driven bench for cdb_arbiter with a few hand-written multi-cycle sequences.
module tb_cdb_arbiter;

    localparam int unsigned NFU = 4;
    localparam int unsigned PRW = 6;
    localparam int unsigned DW  = 32;
    localparam int unsigned NV  = 26;

    localparam logic [DW-1:0]  RES [NFU] = '{32'h0000_0011, 32'h0000_0022, 32'h0000_0033, 32'h0000_0044};
    localparam logic [PRW-1:0] TAG [NFU] = '{6'd5, 6'd9, 6'd17, 6'd0};
    localparam logic           WRE [NFU] = '{1'b1, 1'b1, 1'b1, 1'b0};

    logic                       clock = 1'b0;
    logic                       reset;
    logic                       clear;
    logic [NFU-1:0]             fu_next_valid;
    logic [NFU-1:0][DW-1:0]     fu_result;
    logic [NFU-1:0][PRW-1:0]    fu_dest_tag;
    logic [NFU-1:0]             fu_dest_tag_wr_en;
    logic [NFU-1:0]             fu_broadcasted;
    logic                       cdb_valid;
    logic [DW-1:0]              cdb_data;
    logic [PRW-1:0]             cdb_tag;
    logic                       cdb_wr_en;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic           rst;
        logic           clr;
        logic [NFU-1:0] nv;
        logic [NFU-1:0] bc;
        logic           v;
        logic [DW-1:0]  d;
        logic [PRW-1:0] t;
        logic           w;
    } vec_t;

    vec_t vecs [NV];

    always #5 clock = ~clock;

    cdb_arbiter #(
        .NUM_FU         (NFU),
        .PHYS_REG_WIDTH (PRW)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .clear             (clear),
        .fu_next_valid     (fu_next_valid),
        .fu_result         (fu_result),
        .fu_dest_tag       (fu_dest_tag),
        .fu_dest_tag_wr_en (fu_dest_tag_wr_en),
        .fu_broadcasted    (fu_broadcasted),
        .cdb_valid         (cdb_valid),
        .cdb_data          (cdb_data),
        .cdb_tag           (cdb_tag),
        .cdb_wr_en         (cdb_wr_en)
    );

    // g < 0: idle bus expected; otherwise FU g's constant result on the bus.
    function automatic vec_t mk(input logic rst, input logic clr, input logic [NFU-1:0] nv,
                                input int g);
        vec_t r;
        r.rst = rst;
        r.clr = clr;
        r.nv  = nv;
        if (g < 0) begin
            r.bc = '0;
            r.v  = 1'b0;
            r.d  = '0;
            r.t  = '0;
            r.w  = 1'b0;
        end else begin
            r.bc = NFU'(1) << g;
            r.v  = 1'b1;
            r.d  = RES[g];
            r.t  = TAG[g];
            r.w  = WRE[g];
        end
        return r;
    endfunction

    task automatic check(input string name, input int idx, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic load_const_results();
        for (int i = 0; i < int'(NFU); i++) begin
            fu_result[i]         = RES[i];
            fu_dest_tag[i]       = TAG[i];
            fu_dest_tag_wr_en[i] = WRE[i];
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int seen [NFU];

        reset         = 1'b1;
        clear         = 1'b0;
        fu_next_valid = '0;
        load_const_results();

        vecs[0]  = mk(1'b1, 1'b0, 4'b0000, -1);  // reset: all outputs zero
        vecs[1]  = mk(1'b0, 1'b0, 4'b0001, -1);  // single FU0 request
        vecs[2]  = mk(1'b0, 1'b0, 4'b0000, 0);   // FU0 broadcasts one cycle later
        vecs[3]  = mk(1'b1, 1'b0, 4'b0000, -1);  // reset pointer back to 0
        vecs[4]  = mk(1'b0, 1'b0, 4'b1111, -1);  // all request
        vecs[5]  = mk(1'b0, 1'b0, 4'b1111, 0);
        vecs[6]  = mk(1'b0, 1'b0, 4'b1111, 1);
        vecs[7]  = mk(1'b0, 1'b0, 4'b1111, 2);
        vecs[8]  = mk(1'b0, 1'b0, 4'b1111, 3);   // FU3: wr_en=0, tag 0
        vecs[9]  = mk(1'b0, 1'b0, 4'b0000, 0);
        vecs[10] = mk(1'b0, 1'b0, 4'b0100, -1);  // FU2 grant -> ptr 3
        vecs[11] = mk(1'b0, 1'b0, 4'b1001, 2);   // ptr 3: FU3 wins, ptr wraps to 0
        vecs[12] = mk(1'b0, 1'b0, 4'b1001, 3);   // ptr 0: FU0 wins
        vecs[13] = mk(1'b0, 1'b0, 4'b0000, 0);
        vecs[14] = mk(1'b0, 1'b0, 4'b0010, -1);  // FU1 granted
        vecs[15] = mk(1'b0, 1'b1, 4'b0010, -1);  // clear suppresses bus and next grant
        vecs[16] = mk(1'b0, 1'b0, 4'b0000, -1);
        vecs[17] = mk(1'b0, 1'b0, 4'b0101, -1);  // ptr held at 2: FU2 wins
        vecs[18] = mk(1'b0, 1'b0, 4'b0000, 2);
        vecs[19] = mk(1'b0, 1'b0, 4'b0100, -1);  // FU2 granted, ptr 3
        vecs[20] = mk(1'b1, 1'b0, 4'b1111, -1);  // reset mid-broadcast
        vecs[21] = mk(1'b0, 1'b0, 4'b1111, -1);  // ptr 0 after reset
        vecs[22] = mk(1'b0, 1'b0, 4'b0000, 0);   // FU0 favoured
        vecs[23] = mk(1'b0, 1'b0, 4'b0010, -1);
        vecs[24] = mk(1'b0, 1'b0, 4'b0010, 1);   // back-to-back re-grant of FU1
        vecs[25] = mk(1'b0, 1'b0, 4'b0000, 1);

        for (int i = 0; i < int'(NV); i++) begin
            step();
            reset         = vecs[i].rst;
            clear         = vecs[i].clr;
            fu_next_valid = vecs[i].nv;
            @(negedge clock);
            check("fu_broadcasted", i, 64'(fu_broadcasted), 64'(vecs[i].bc));
            check("cdb_valid", i, 64'(cdb_valid), 64'(vecs[i].v));
            check("cdb_data", i, 64'(cdb_data), 64'(vecs[i].d));
            check("cdb_tag", i, 64'(cdb_tag), 64'(vecs[i].t));
            check("cdb_wr_en", i, 64'(cdb_wr_en), 64'(vecs[i].w));
        end

        // Bus data follows FU3's held inputs; a new request mid-cycle does not disturb the ack.
        step();
        fu_next_valid = 4'b1000;
        @(negedge clock);
        check("seqA_idle", 0, 64'(fu_broadcasted), 64'h0);
        step();
        fu_next_valid        = 4'b0000;
        fu_result[3]         = 32'hdead_beef;
        fu_dest_tag[3]       = 6'd42;
        fu_dest_tag_wr_en[3] = 1'b1;
        @(negedge clock);
        check("seqA_data", 1, 64'(cdb_data), 64'hdead_beef);
        check("seqA_tag", 1, 64'(cdb_tag), 64'd42);
        check("seqA_wr_en", 1, 64'(cdb_wr_en), 64'h1);
        fu_next_valid = 4'b1111;
        #1;
        check("seqA_no_comb_path", 1, 64'(fu_broadcasted), 64'b1000);
        step();
        fu_next_valid = 4'b0000;
        load_const_results();
        @(negedge clock);
        check("seqA_next_fu0", 2, 64'(fu_broadcasted), 64'b0001);
        check("seqA_next_data", 2, 64'(cdb_data), 64'h11);

        // Fairness: under full load every FU is acked exactly twice in eight cycles.
        step();
        fu_next_valid = 4'b1111;
        @(negedge clock);
        check("seqB_fill", 0, 64'(cdb_valid), 64'h0);
        for (int i = 0; i < int'(NFU); i++) seen[i] = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            @(negedge clock);
            check("seqB_onehot", c, 64'($countones(fu_broadcasted)), 64'd1);
            for (int i = 0; i < int'(NFU); i++) begin
                if (fu_broadcasted[i]) seen[i]++;
            end
        end
        for (int i = 0; i < int'(NFU); i++) begin
            check("seqB_fair", i, 64'(seen[i]), 64'd2);
        end
        step();
        fu_next_valid = 4'b0000;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
